// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time loader that writes a framed, checksummed byte stream
// into instruction memory and holds the CPU in reset until a good frame lands.
module instr_mem_loader #(
    parameter int MEM_WORDS = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             imem_we_o,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      imem_data_o,
    output logic             cpu_rst_n_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_loaded_o
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR} state_t;

    state_t           r_state;
    logic [7:0]       r_len_hi;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_widx;
    logic [1:0]       r_bcnt;
    logic [23:0]      r_word;
    logic [7:0]       r_csum;

    state_t           w_next;
    logic             w_xfer;
    logic             w_go;
    logic             w_last;
    logic [CNT_W-1:0] w_len;

    always_comb begin
        w_xfer = byte_valid_i && byte_ready_o;
        w_go   = start_i && (r_state == IDLE || r_state == DONE || r_state == ERR);
        w_len  = CNT_W'({r_len_hi, byte_data_i});
        w_last = (r_bcnt == 2'd3) && (r_widx == r_len - 1'b1);
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: w_next = w_go ? LEN_HI : r_state;
            LEN_HI:          w_next = w_xfer ? LEN_LO : LEN_HI;
            LEN_LO:          w_next = !w_xfer ? LEN_LO :
                                      (w_len > CNT_W'(MEM_WORDS)) ? ERR :
                                      (w_len == '0) ? CHECK : DATA;
            DATA:            w_next = (w_xfer && w_last) ? CHECK : DATA;
            CHECK:           w_next = !w_xfer ? CHECK :
                                      (byte_data_i == r_csum) ? DONE : ERR;
            default:         w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_len_hi       <= '0;
            r_len          <= '0;
            r_widx         <= '0;
            r_bcnt         <= '0;
            r_word         <= '0;
            r_csum         <= '0;
            byte_ready_o   <= 1'b0;
            imem_we_o      <= 1'b0;
            imem_addr_o    <= '0;
            imem_data_o    <= '0;
            cpu_rst_n_o    <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            words_loaded_o <= '0;
        end else begin
            r_state      <= w_next;
            byte_ready_o <= (w_next == LEN_HI) || (w_next == LEN_LO) ||
                            (w_next == DATA)   || (w_next == CHECK);
            cpu_rst_n_o  <= (w_next == DONE);
            done_o       <= (w_next == DONE);
            err_o        <= (w_next == ERR);
            imem_we_o    <= 1'b0;
            if (w_go) begin
                r_csum         <= '0;
                r_widx         <= '0;
                r_bcnt         <= '0;
                words_loaded_o <= '0;
            end
            if (w_xfer && r_state != CHECK)
                r_csum <= r_csum ^ byte_data_i;
            if (w_xfer && r_state == LEN_HI)
                r_len_hi <= byte_data_i;
            if (w_xfer && r_state == LEN_LO)
                r_len <= w_len;
            if (w_xfer && r_state == DATA) begin
                r_bcnt <= r_bcnt + 2'd1;
                r_word <= {r_word[15:0], byte_data_i};
                if (r_bcnt == 2'd3) begin
                    imem_we_o      <= 1'b1;
                    imem_addr_o    <= 32'({r_widx, 2'b00});
                    imem_data_o    <= {r_word, byte_data_i};
                    r_widx         <= r_widx + 1'b1;
                    words_loaded_o <= words_loaded_o + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench for instr_mem_loader.
module tb_instr_mem_loader;
    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = '0;
    logic        byte_ready_o;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_o;
    logic        cpu_rst_n_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] words_loaded_o;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    logic [63:0] sb[$];
    logic [7:0]  fr[$];

    instr_mem_loader #(.MEM_WORDS(32), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
        .cpu_rst_n_o(cpu_rst_n_o), .done_o(done_o), .err_o(err_o),
        .words_loaded_o(words_loaded_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_n && imem_we_o) begin
            n_wr++;
            if (sb.size() == 0) chk("wr_extra", {imem_addr_o, imem_data_o}, 64'd0);
            else chk("wr_addr_data", {imem_addr_o, imem_data_o}, sb.pop_front());
        end
    end

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        while (!byte_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    // Builds fr = {LEN, payload, xor}; payload words either from w0/w1 pattern or random.
    task automatic build(input int len, input logic rnd, input logic [7:0] xor_flip);
        logic [7:0] x = 8'h00;
        logic [31:0] w;
        fr.delete();
        fr.push_back(8'(len >> 8));
        fr.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            w = rnd ? $urandom : (i == 0 ? 32'h20080005 : 32'h0);
            for (int k = 3; k >= 0; k--) fr.push_back(w[k*8 +: 8]);
        end
        foreach (fr[i]) x = x ^ fr[i];
        fr.push_back(x ^ xor_flip);
    endtask

    task automatic run_frame(input int gapmax, input logic extra_starts);
        int len = {fr[0], fr[1]};
        pulse_start();
        if (extra_starts) pulse_start();
        foreach (fr[i]) begin
            if (len <= 32 && i >= 2 && i < 2 + 4*len && (i - 2) % 4 == 3)
                sb.push_back({32'((i - 2) / 4 * 4), fr[i-3], fr[i-2], fr[i-1], fr[i]});
            send(fr[i]);
            if (extra_starts && i == 4) pulse_start();
            if (gapmax > 0) repeat ($urandom_range(1, gapmax)) @(negedge clk_i);
        end
        @(negedge clk_i);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_end(input logic d, input logic e, input int wl);
        chk("done", 64'(done_o), 64'(d));
        chk("err", 64'(err_o), 64'(e));
        chk("cpu_rst_n", 64'(cpu_rst_n_o), 64'(d));
        chk("ready_idle", 64'(byte_ready_o), 64'd0);
        chk("words_loaded", 64'(words_loaded_o), 64'(wl));
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", 64'(byte_ready_o), 64'd0);
        chk("rst_we", 64'(imem_we_o), 64'd0);
        chk("rst_addr_data", {imem_addr_o, imem_data_o}, 64'd0);
        chk("rst_flags", {61'd0, cpu_rst_n_o, done_o, err_o}, 64'd0);
        chk("rst_wl", 64'(words_loaded_o), 64'd0);
    endtask

    initial begin
        int w0;
        repeat (2) @(negedge clk_i);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", 64'(byte_ready_o), 64'd0);

        build(2, 1'b0, 8'h00);
        chk("frame_xor", 64'(fr[10]), 64'h2F);
        run_frame(0, 1'b0);
        chk_end(1'b1, 1'b0, 2);

        build(2, 1'b0, 8'h00);
        run_frame(3, 1'b0);
        chk_end(1'b1, 1'b0, 2);

        build(2, 1'b0, 8'h01);
        chk("bad_xor", 64'(fr[10]), 64'h2E);
        w0 = n_wr;
        run_frame(0, 1'b0);
        chk("bad_writes", 64'(n_wr - w0), 64'd2);
        chk_end(1'b0, 1'b1, 2);
        build(2, 1'b0, 8'h00);
        run_frame(1, 1'b0);
        chk_end(1'b1, 1'b0, 2);

        w0 = n_wr;
        pulse_start();
        send(8'h00);
        send(8'h21);
        chk("len_err", 64'(err_o), 64'd1);
        chk("len_err_ready", 64'(byte_ready_o), 64'd0);
        repeat (3) @(negedge clk_i);
        chk("len_err_writes", 64'(n_wr - w0), 64'd0);
        chk_end(1'b0, 1'b1, 0);

        build(0, 1'b0, 8'h00);
        w0 = n_wr;
        run_frame(0, 1'b0);
        chk("zero_writes", 64'(n_wr - w0), 64'd0);
        chk_end(1'b1, 1'b0, 0);
        build(2, 1'b0, 8'h00);
        run_frame(2, 1'b1);
        chk_end(1'b1, 1'b0, 2);

        build(32, 1'b1, 8'h00);
        w0 = n_wr;
        run_frame(0, 1'b0);
        chk("full_writes", 64'(n_wr - w0), 64'd32);
        chk("last_addr", 64'(imem_addr_o), 64'h7C);
        chk_end(1'b1, 1'b0, 32);

        build(2, 1'b0, 8'h00);
        sb.push_back({32'h0, 32'h20080005});
        pulse_start();
        for (int i = 0; i < 8; i++) send(fr[i]);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        sb.delete();
        @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        chk("post_rst_idle", 64'(byte_ready_o), 64'd0);
        run_frame(0, 1'b0);
        chk_end(1'b1, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Boot-time writer for the instruction memory that the single-cycle CPU fetches from.
- Accepts a framed byte stream over a valid/ready interface.
- Assembles big-endian 32-bit instruction words and drives a synchronous write port into instruction memory at byte addresses 0, 4, 8, …
- Holds the CPU in reset until a frame loads with a correct checksum, then releases it.

Parameters:
MEM_WORDS, 32, instruction memory depth in words; largest legal frame length.
CNT_W, 16, width of the frame length field and of the word counters.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low, fixed).
start_i  input  1  one-cycle pulse; begins a new load; honoured only in IDLE, DONE or ERR.
byte_valid_i  input  1  byte_data_i holds a valid byte.
byte_data_i  input  8  stream byte.
byte_ready_o  output  1  loader can accept a byte this cycle.
imem_we_o  output  1  one-cycle write strobe to instruction memory.
imem_addr_o  output  32  byte address of the write; always word-aligned.
imem_data_o  output  32  instruction word to write.
cpu_rst_n_o  output  1  active-low reset to the CPU; high only in DONE.
done_o  output  1  load completed and checksum matched.
err_o  output  1  load aborted (length too large or checksum mismatch).
words_loaded_o  output  CNT_W  number of words written in the current or last load.

Behaviour:
Frame format:
- Byte 0: LEN[15:8]. Byte 1: LEN[7:0].
- Then 4*LEN payload bytes, MSB of each word first.
- Then 1 checksum byte, equal to the XOR of all preceding frame bytes, including the length bytes.

Handshake:
- A byte transfers on a rising edge where byte_valid_i && byte_ready_o.
- byte_ready_o is a registered function of state: 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 otherwise.
- Back-to-back transfers every cycle are supported. Gaps in byte_valid_i are tolerated indefinitely.

State machine:
- IDLE → LEN_HI on start_i.
- LEN_HI → LEN_LO on transfer.
- LEN_LO → on transfer:
  - ERR if LEN > MEM_WORDS;
  - CHECK if LEN == 0;
  - DATA otherwise.
- DATA: a 2-bit byte counter shifts bytes into the word register.
  - On the 4th byte of a word, the next cycle drives imem_we_o=1 with imem_addr_o = 4*word_idx and imem_data_o = assembled word (1-cycle write latency); word_idx then increments.
  - After the LENth word's 4th byte → CHECK.
  - A byte of the next word may be accepted in the same cycle as the write strobe.
- CHECK → on transfer, DONE if the byte equals the running XOR, else ERR.
- DONE, ERR → LEN_HI on start_i. The running XOR, word_idx, byte counter and words_loaded_o clear on that transition.
- start_i is ignored in LEN_HI, LEN_LO, DATA and CHECK.

Outputs per state:
- cpu_rst_n_o = 1 only in DONE.
- done_o = 1 only in DONE.
- err_o = 1 only in ERR.
- words_loaded_o increments with each imem_we_o pulse and holds its value in DONE and ERR.

Reset:
- Asynchronous, effective on assertion regardless of state.
- State = IDLE. byte_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_data_o=0, cpu_rst_n_o=0, done_o=0, err_o=0, words_loaded_o=0.
- A reset mid-load abandons the frame. Memory contents are then undefined and the CPU stays in reset.

Boundaries:
- LEN == MEM_WORDS is legal; the last write goes to address 4*(MEM_WORDS-1).
- Addresses never exceed 4*(MEM_WORDS-1).
- On a checksum mismatch, already-written words are not rolled back.

Test Plan:
1. start_i, then bytes 00 02 20 08 00 05 00 00 00 00 2F back-to-back → imem_we_o pulses with (addr 0x0, data 0x20080005) then (addr 0x4, data 0x00000000); done_o=1; cpu_rst_n_o=1; words_loaded_o=2.
2. Same frame with 1–3 idle cycles between bytes (random byte_valid_i) → identical writes and final state; no duplicate or missed bytes.
3. Same frame with checksum 0x2E → both writes still occur; err_o=1; done_o=0; cpu_rst_n_o stays 0; start_i then reloads successfully.
4. Length bytes 00 21 with MEM_WORDS=32 → err_o=1 in the cycle after the LEN_LO transfer; zero imem_we_o pulses; byte_ready_o=0.
5. Frame 00 00 00 → done_o=1, no writes, words_loaded_o=0; a start_i pulse during LEN_HI/DATA of a following load has no effect.
6. Assert rst_n low midway through payload word 1 → all outputs return to reset values immediately; state is IDLE after release; a full frame then loads correctly from address 0.
